// File: rtl/regfile_onehot_wr.sv
// Architectural register file with a one-hot write select, two combinational read ports,
// optional same-cycle write bypass, a sticky illegal-select flag and a committed-write counter.
module regfile_onehot_wr #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ZERO_REG   = 31,
  parameter int BYPASS     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REGS-1:0]         wr_sel,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_a,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0]       rd_data_a,
  output logic [DATA_WIDTH-1:0]       rd_data_b,
  output logic                        sel_err,
  output logic [15:0]                 wr_count
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  sel_any;
  logic                  sel_multi;
  logic                  sel_onehot;
  logic                  commit;
  logic [AW-1:0]         wr_idx;
  logic                  sel_err_reg;
  logic [15:0]           wr_count_reg;

  // Single pass over wr_sel: a set bit seen after another set bit means more than one.
  always_comb begin
    sel_any   = 1'b0;
    sel_multi = 1'b0;
    wr_idx    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_sel[i]) begin
        if (sel_any) sel_multi = 1'b1;
        sel_any = 1'b1;
        wr_idx  = i[AW-1:0];
      end
    end
  end

  assign sel_onehot = sel_any & ~sel_multi;
  assign commit     = sel_onehot && (wr_idx != ZERO_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      sel_err_reg  <= 1'b0;
      wr_count_reg <= '0;
    end else begin
      if (sel_multi) sel_err_reg <= 1'b1;
      if (commit) begin
        regs[wr_idx] <= wr_data;
        wr_count_reg <= wr_count_reg + 16'd1;
      end
    end
  end

  assign sel_err  = sel_err_reg;
  assign wr_count = wr_count_reg;

  // Zero-register check takes priority over bypass so XZR always reads as zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
    assign addr = (gi == 0) ? rd_addr_a : rd_addr_b;
    always_comb begin
      if (addr == ZERO_IDX)
        data = '0;
      else if ((BYPASS != 0) && sel_onehot && (wr_idx == addr))
        data = wr_data;
      else
        data = regs[addr];
    end
  end

  assign rd_data_a = g_rd[0].data;
  assign rd_data_b = g_rd[1].data;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Randomized and directed bench for regfile_onehot_wr; a bypassing and a non-bypassing
// instance share stimulus and are compared against an array-based reference model.
module tb_regfile_onehot_wr;

  logic        clk;
  logic        reset;
  logic [31:0] wr_sel;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [63:0] rd_data_a, rd_data_b, nb_data_a, nb_data_b;
  logic        sel_err, nb_sel_err;
  logic [15:0] wr_count, nb_wr_count;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mem [32];
  logic        m_err;
  int          m_cnt;

  regfile_onehot_wr #(.NUM_REGS(32), .DATA_WIDTH(64), .ZERO_REG(31), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .sel_err(sel_err), .wr_count(wr_count)
  );

  regfile_onehot_wr #(.NUM_REGS(32), .DATA_WIDTH(64), .ZERO_REG(31), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(nb_data_a), .rd_data_b(nb_data_b),
    .sel_err(nb_sel_err), .wr_count(nb_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return 64'd0;
    if (byp && $countones(wr_sel) == 1 && $clog2(wr_sel) == int'(a)) return wr_data;
    return mem[a];
  endfunction

  // Drive one cycle; optionally check all outputs before the edge, then advance the model.
  task automatic cycle(input logic rst, input logic [31:0] sel, input logic [63:0] data,
                       input logic [4:0] ra, input logic [4:0] rb, input bit chk);
    int k;
    reset = rst; wr_sel = sel; wr_data = data; rd_addr_a = ra; rd_addr_b = rb;
    @(negedge clk);
    if (chk) begin
      check("rd_a",     rd_data_a,   exp_read(ra, 1'b1));
      check("rd_b",     rd_data_b,   exp_read(rb, 1'b1));
      check("nb_rd_a",  nb_data_a,   exp_read(ra, 1'b0));
      check("nb_rd_b",  nb_data_b,   exp_read(rb, 1'b0));
      check("sel_err",  {63'd0, sel_err},    {63'd0, m_err});
      check("wr_count", {48'd0, wr_count},   64'(m_cnt));
      check("nb_count", {48'd0, nb_wr_count}, 64'(m_cnt));
      check("nb_err",   {63'd0, nb_sel_err}, {63'd0, m_err});
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 64'd0;
      m_err = 1'b0;
      m_cnt = 0;
    end else if ($countones(sel) == 1) begin
      k = $clog2(sel);
      if (k != 31) begin
        mem[k] = data;
        m_cnt  = (m_cnt + 1) % 65536;
      end
    end else if ($countones(sel) > 1) begin
      m_err = 1'b1;
    end
    #1;
  endtask

  initial begin
    int r, k, k2, last_k;
    logic [31:0] sel;
    logic [63:0] data, last_data;
    logic [4:0]  ra, rb;
    logic        rst;

    for (int i = 0; i < 32; i++) mem[i] = 64'd0;
    m_err = 1'b0; m_cnt = 0;
    reset = 1'b1; wr_sel = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    @(posedge clk); #1;

    // Reset then read
    cycle(1'b1, 32'd0, 64'd0, 5'd5, 5'd30, 1'b0);
    cycle(1'b1, 32'd0, 64'd0, 5'd5, 5'd30, 1'b1);
    cycle(1'b0, 32'd0, 64'd0, 5'd5, 5'd30, 1'b1);

    // Basic write then read
    cycle(1'b0, 32'd1 << 3, 64'h0123_4567_89AB_CDEF, 5'd3, 5'd0, 1'b1);
    cycle(1'b0, 32'd0, 64'd0, 5'd3, 5'd3, 1'b1);
    check("basic_rd", rd_data_a, 64'h0123_4567_89AB_CDEF);

    // Same-cycle bypass on both ports
    cycle(1'b0, 32'd1 << 7, 64'hDEAD, 5'd7, 5'd7, 1'b1);
    cycle(1'b0, 32'd0, 64'd0, 5'd7, 5'd7, 1'b1);
    check("nb_after", nb_data_a, 64'hDEAD);

    // Zero register write is discarded
    cycle(1'b0, 32'd1 << 31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b1);
    cycle(1'b0, 32'd0, 64'd0, 5'd31, 5'd0, 1'b1);

    // Illegal multi-bit select
    cycle(1'b0, 32'd1 << 1, 64'h11, 5'd1, 5'd2, 1'b1);
    cycle(1'b0, 32'd1 << 2, 64'h22, 5'd1, 5'd2, 1'b1);
    cycle(1'b0, 32'h6, 64'h99, 5'd1, 5'd2, 1'b1);
    cycle(1'b0, 32'd0, 64'd0, 5'd1, 5'd2, 1'b1);
    check("multi_r2", rd_data_b, 64'h22);
    cycle(1'b0, 32'd1 << 9, 64'h909, 5'd9, 5'd1, 1'b1);
    cycle(1'b0, 32'd0, 64'd0, 5'd9, 5'd1, 1'b1);
    check("err_sticky", {63'd0, sel_err}, 64'd1);

    // Reset colliding with a write
    cycle(1'b1, 32'd1 << 4, 64'h44, 5'd4, 5'd9, 1'b1);
    cycle(1'b0, 32'd0, 64'd0, 5'd4, 5'd9, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r    = $urandom_range(0, 9);
      k    = $urandom_range(0, 31);
      data = {$urandom, $urandom};
      rst  = ($urandom_range(0, 59) == 0);
      case (r)
        0:       sel = 32'd0;
        6, 7: begin
          k2  = (k + 1 + $urandom_range(0, 30)) % 32;
          sel = (32'd1 << k) | (32'd1 << k2);
        end
        default: sel = 32'd1 << k;
      endcase
      ra = ($urandom_range(0, 1) == 0) ? 5'(k) : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? 5'(k) : 5'($urandom_range(0, 31));
      cycle(rst, sel, data, ra, rb, 1'b1);
    end

    // Counter wrap: 65536 committed writes from a fresh reset
    cycle(1'b1, 32'd0, 64'd0, 5'd0, 5'd0, 1'b1);
    last_k = 0; last_data = 64'd0;
    for (int n = 0; n < 65536; n++) begin
      last_k    = $urandom_range(0, 30);
      last_data = {$urandom, $urandom};
      cycle(1'b0, 32'd1 << last_k, last_data, 5'd0, 5'd0, 1'b0);
    end
    cycle(1'b0, 32'd0, 64'd0, 5'(last_k), 5'd31, 1'b1);
    check("wrap_count", {48'd0, wr_count}, 64'd0);
    check("wrap_last", rd_data_a, last_data);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_onehot_wr.md
Name: regfile_onehot_wr

Overview:
- Architectural register file for the pipelined ARM datapath: NUM_REGS x DATA_WIDTH storage with two combinational read ports and one write port.
- Sits directly downstream of the write-address decoder. The decoder's one-hot output drives wr_sel, so this block never decodes a binary write address itself.
- Provides write-to-read bypass so the decode stage sees a writeback happening in the same cycle.
- Flags illegal (non-one-hot) write selects with a sticky error bit.

Parameters:
- NUM_REGS, 32, number of registers; power of 2, >= 2.
- DATA_WIDTH, 64, register width in bits.
- ZERO_REG, 31, index of the hardwired-zero register (XZR); writes to it are discarded.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see old contents.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_sel  input  NUM_REGS  one-hot write select from the decoder; all-zero = no write.
- wr_data  input  DATA_WIDTH  write data.
- rd_addr_a  input  $clog2(NUM_REGS)  read port A address.
- rd_addr_b  input  $clog2(NUM_REGS)  read port B address.
- rd_data_a  output  DATA_WIDTH  read port A data, combinational.
- rd_data_b  output  DATA_WIDTH  read port B data, combinational.
- sel_err  output  1  sticky: set when wr_sel had more than one bit set.
- wr_count  output  16  count of committed writes; wraps modulo 2^16.

Behaviour:
- Reset (synchronous):
  - On a clk rising edge with reset=1, all registers, sel_err and wr_count go to 0.
  - wr_sel is ignored during that cycle.
  - A write presented in the same cycle as reset is lost.
- Write validity is combinational on the current wr_sel:
  - onehot = exactly one bit set.
  - multi = two or more bits set.
  - none = all zero.
- Commit: at a rising edge with reset=0 and onehot, and the set bit index k != ZERO_REG, reg[k] <= wr_data and wr_count increments by 1. Latency: visible to non-bypass reads on the next cycle.
- onehot with k == ZERO_REG: no storage change, wr_count unchanged, no error.
- multi:
  - No register is written, not even partially.
  - wr_count unchanged.
  - sel_err <= 1 and stays set until reset.
- none: idle; state unchanged.
- Reads:
  - rd_data_x = 0 when rd_addr_x == ZERO_REG, regardless of storage or bypass.
  - Otherwise, if BYPASS=1, the write is onehot, and k == rd_addr_x, rd_data_x = wr_data (same cycle).
  - Otherwise rd_data_x = reg[rd_addr_x].
- Both read ports are independent; both may read the same address, including the address being written.
- reset=1 does not force read outputs combinationally. The zeroing is seen after the reset edge.
- Reset mid-operation: with reset held for several cycles, every write is discarded; the first write is accepted on the first edge with reset=0.
- wr_count wrap: 16'hFFFF plus a commit gives 16'h0000; no flag.
- Error detection uses a population count (or an equivalent "more than one bit" reduction) on wr_sel, sized for NUM_REGS.
- Verification assertions:
  - rd_data is 0 whenever rd_addr == ZERO_REG.
  - No storage change occurs in any cycle where wr_sel is multi.

Test Plan:
- Reset then read: hold reset 2 cycles, release; rd_addr_a=5, rd_addr_b=30 -> rd_data_a=0, rd_data_b=0, sel_err=0, wr_count=0.
- Basic write/read: wr_sel=1<<3, wr_data=64'h0123_4567_89AB_CDEF for one cycle, then wr_sel=0; rd_addr_a=3 next cycle -> 64'h0123_4567_89AB_CDEF; wr_count=1.
- Same-cycle bypass (BYPASS=1): wr_sel=1<<7, wr_data=64'hDEAD, rd_addr_a=rd_addr_b=7 in the same cycle.
  - Expect rd_data_a=rd_data_b=64'hDEAD before the edge.
  - With BYPASS=0, expect the old value 0 before the edge and 64'hDEAD after.
- Zero register: wr_sel=1<<31, wr_data=64'hFFFF_FFFF_FFFF_FFFF; rd_addr_a=31 before and after the edge -> 0; wr_count unchanged; sel_err=0.
- Illegal select: preload reg1=64'h11 and reg2=64'h22, then wr_sel=32'h6, wr_data=64'h99.
  - Expect reg1=64'h11, reg2=64'h22, sel_err=1, and no bypass of 64'h99 on reads of 1 or 2.
  - sel_err remains 1 across subsequent legal writes until reset.
- Reset vs write collision and counter wrap: wr_sel=1<<4, wr_data=64'h44 with reset=1 in the same cycle -> reg4=0 after the edge.
  - Then perform 65536 legal writes -> wr_count=0 and the last written value readable.
